// File: rtl/snake_pkg.sv
// Shared definitions for the snake body store and its scanner: coordinate
// type, default geometry and the scan FSM state encoding.
package snake_pkg;

  localparam int COORD_XW     = 6;
  localparam int COORD_YW     = 5;
  localparam int BODY_MAX_LEN = 8;

  typedef struct packed {
    logic [COORD_XW-1:0] x;
    logic [COORD_YW-1:0] y;
  } coord_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } scan_state_t;

  function automatic coord_t coord_pack(input logic [COORD_XW-1:0] x,
                                        input logic [COORD_YW-1:0] y);
    coord_t c;
    c.x = x;
    c.y = y;
    return c;
  endfunction

endpackage

// File: rtl/snake_body_scanner_if.sv
// Indexed synchronous read port into the snake body store; the scanner is
// the master, the store answers one cycle after rd_en.
interface snake_body_scanner_if
  import snake_pkg::*;
#(
  parameter int AW = $clog2(BODY_MAX_LEN),
  parameter int DW = COORD_XW + COORD_YW
);

  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;

  modport master (
    output rd_en,
    output rd_addr,
    input  rd_data
  );

  modport slave (
    input  rd_en,
    input  rd_addr,
    output rd_data
  );

endinterface

// File: rtl/snake_body_scanner.sv
// Walks the stored body head-first and reports the lowest index matching a
// query coordinate. SNAKE_SCAN_EARLY_EXIT_EN stops the walk on the first hit.
module snake_body_scanner
  import snake_pkg::*;
#(
  parameter  int XW      = COORD_XW,
  parameter  int YW      = COORD_YW,
  parameter  int MAX_LEN = BODY_MAX_LEN,
  localparam int AW      = $clog2(MAX_LEN)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [XW+YW-1:0]     query,
  input  logic [7:0]           length,
  input  logic                 ignore_tail,
  snake_body_scanner_if.master rd,
  output logic                 busy,
  output logic                 done,
  output logic                 hit,
  output logic [AW-1:0]        hit_idx
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int DW = XW + YW;

  scan_state_t   state_q, state_d;
  logic [AW-1:0] idx_q;
  logic [AW-1:0] last_q;
  logic [AW-1:0] cmp_idx_q;
  logic          cmp_vld_q;
  logic [DW-1:0] query_q;

  logic [7:0]    len_clamp;
  logic [LW-1:0] limit_c;
  logic          accept;
  logic          issue;
  logic          match;

  always_comb begin
    len_clamp = (length > 8'(MAX_LEN)) ? 8'(MAX_LEN) : length;
    limit_c   = LW'(len_clamp);
    if (ignore_tail && (limit_c != '0)) begin
      limit_c = limit_c - LW'(1);
    end
  end

  // Only the first match is recorded; hit itself masks later duplicates.
  assign match = cmp_vld_q && (rd.rd_data == query_q) && !hit;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = (limit_c == '0) ? DONE : SCAN;
        end
      end
      SCAN: begin
        issue = 1'b1;
        if (idx_q == last_q) begin
          state_d = DRAIN;
        end
`ifdef SNAKE_SCAN_EARLY_EXIT_EN
        if (match) begin
          state_d = DONE;
        end
`endif
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rd.rd_en   = issue;
  assign rd.rd_addr = issue ? idx_q : '0;
  assign busy       = (state_q == SCAN) || (state_q == DRAIN);
  assign done       = (state_q == DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      last_q    <= '0;
      cmp_idx_q <= '0;
      cmp_vld_q <= 1'b0;
      query_q   <= '0;
      hit       <= 1'b0;
      hit_idx   <= '0;
    end else begin
      state_q   <= state_d;
      cmp_vld_q <= issue;
      cmp_idx_q <= idx_q;
      if (accept) begin
        idx_q   <= '0;
        last_q  <= AW'(limit_c - LW'(1));
        query_q <= query;
        hit     <= 1'b0;
        hit_idx <= '0;
      end else begin
        if (issue) begin
          idx_q <= idx_q + AW'(1);
        end
        if (match) begin
          hit     <= 1'b1;
          hit_idx <= cmp_idx_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_snake_body_scanner.sv
// Scoreboard bench for snake_body_scanner with a 1-cycle-latency body store.
module tb_snake_body_scanner;
  import snake_pkg::*;

  localparam int XW      = COORD_XW;
  localparam int YW      = COORD_YW;
  localparam int MAX_LEN = BODY_MAX_LEN;
  localparam int AW      = $clog2(MAX_LEN);
  localparam int DW      = XW + YW;

  typedef struct {
    logic          hit;
    logic [AW-1:0] idx;
    int            t_acc;
    int            lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] query = '0;
  logic [7:0]    length = '0;
  logic          ignore_tail = 1'b0;
  logic          busy, done, hit;
  logic [AW-1:0] hit_idx;

  snake_body_scanner_if #(.AW(AW), .DW(DW)) rd_bus ();

  snake_body_scanner #(.XW(XW), .YW(YW), .MAX_LEN(MAX_LEN)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .query      (query),
    .length     (length),
    .ignore_tail(ignore_tail),
    .rd         (rd_bus),
    .busy       (busy),
    .done       (done),
    .hit        (hit),
    .hit_idx    (hit_idx)
  );

  coord_t mem [MAX_LEN];
  int     cyc = 0;
  int     checks = 0;
  int     passed = 0;
  int     done_cnt = 0;
  exp_t   exp_q [$];
  int     read_log [$];
  exp_t   mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (rd_bus.rd_en) rd_bus.rd_data <= mem[rd_bus.rd_addr];

  always @(negedge clk) begin
    if (reset_n) begin
      if (rd_bus.rd_en) read_log.push_back(int'(rd_bus.rd_addr));
      if (done) begin
        done_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL done_unexpected: done pulse at cycle %0d, want no outstanding scan", cyc);
        end else begin
          passed++;
          mon_e = exp_q.pop_front();
          checks++;
          if (hit === mon_e.hit) passed++;
          else $display("FAIL result_hit: got %0b, want %0b (accept %0d)", hit, mon_e.hit, mon_e.t_acc);
          checks++;
          if (hit_idx === mon_e.idx) passed++;
          else $display("FAIL result_hit_idx: got %0d, want %0d (accept %0d)", hit_idx, mon_e.idx, mon_e.t_acc);
          checks++;
          if (cyc + 1 - mon_e.t_acc == mon_e.lat) passed++;
          else $display("FAIL result_latency: got %0d, want %0d (accept %0d)", cyc + 1 - mon_e.t_acc, mon_e.lat, mon_e.t_acc);
        end
      end
    end
  end

  task automatic fill_default();
    for (int i = 0; i < MAX_LEN; i++) mem[i] = coord_pack(6'd40, 5'(i));
  endtask

  // Called at a negedge with the DUT idle; accept happens on the next edge.
  task automatic issue(input coord_t q, input int len, input logic ign,
                       input logic eh, input int ei, input int lat);
    exp_t e;
    query = q; length = 8'(len); ignore_tail = ign; start = 1'b1;
    e.hit = eh; e.idx = AW'(ei); e.t_acc = cyc + 1; e.lat = lat;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    ok = (exp_q.size() == 0);
    repeat (2) @(negedge clk);
  endtask

  function automatic int out_of_order();
    int bad = 0;
    foreach (read_log[i]) if (read_log[i] != i) bad++;
    return bad;
  endfunction

  task automatic test_reset();
    int seen = 0;
    #1 reset_n = 1'b0;
    #2;
    checks++; if (rd_bus.rd_en === 1'b0) passed++; else $display("FAIL reset_rd_en: got %0b, want 0", rd_bus.rd_en);
    checks++; if (rd_bus.rd_addr === '0) passed++; else $display("FAIL reset_rd_addr: got %0d, want 0", rd_bus.rd_addr);
    checks++; if (busy === 1'b0) passed++; else $display("FAIL reset_busy: got %0b, want 0", busy);
    checks++; if (done === 1'b0) passed++; else $display("FAIL reset_done: got %0b, want 0", done);
    checks++; if (hit === 1'b0) passed++; else $display("FAIL reset_hit: got %0b, want 0", hit);
    checks++; if (hit_idx === '0) passed++; else $display("FAIL reset_hit_idx: got %0d, want 0", hit_idx);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (rd_bus.rd_en !== 1'b0 || busy !== 1'b0) seen++;
    end
    checks++; if (seen == 0) passed++; else $display("FAIL idle_quiet: got %0d active cycles, want 0", seen);
  endtask

  task automatic test_miss();
    bit ok;
    fill_default();
    mem[0] = coord_pack(6'd13, 5'd1); mem[1] = coord_pack(6'd12, 5'd1); mem[2] = coord_pack(6'd11, 5'd1);
    read_log.delete();
    issue(coord_pack(6'd5, 5'd5), 3, 1'b0, 1'b0, 0, 5);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (busy === 1'b1 && rd_bus.rd_en === (k < 3) && (k >= 3 || rd_bus.rd_addr === AW'(k))) passed++;
      else $display("FAIL miss_cycle%0d: got busy=%0b rd_en=%0b rd_addr=%0d, want busy=1 rd_en=%0b rd_addr=%0d",
                    k + 1, busy, rd_bus.rd_en, rd_bus.rd_addr, k < 3, (k < 3) ? k : 0);
      @(negedge clk);
    end
    checks++;
    if (busy === 1'b0 && done === 1'b1) passed++;
    else $display("FAIL miss_done_cycle: got busy=%0b done=%0b, want busy=0 done=1", busy, done);
    wait_idle(ok);
    checks++; if (ok) passed++; else $display("FAIL miss_timeout: got no done in 40 cycles, want done");
    checks++;
    if (read_log.size() == 3 && out_of_order() == 0) passed++;
    else $display("FAIL miss_reads: got %0d reads (%0d out of order), want 3 in order", read_log.size(), out_of_order());
  endtask

  task automatic test_dup_hit();
    bit ok;
    int nreads;
    fill_default();
    mem[0] = coord_pack(6'd13, 5'd1); mem[1] = coord_pack(6'd12, 5'd1);
    mem[2] = coord_pack(6'd12, 5'd1); mem[3] = coord_pack(6'd10, 5'd1);
    read_log.delete();
`ifdef SNAKE_SCAN_EARLY_EXIT_EN
    issue(coord_pack(6'd12, 5'd1), 4, 1'b0, 1'b1, 1, 4);
    nreads = 3;
`else
    issue(coord_pack(6'd12, 5'd1), 4, 1'b0, 1'b1, 1, 6);
    nreads = 4;
`endif
    wait_idle(ok);
    checks++; if (ok) passed++; else $display("FAIL dup_timeout: got no done in 40 cycles, want done");
    checks++;
    if (read_log.size() == nreads && out_of_order() == 0) passed++;
    else $display("FAIL dup_reads: got %0d reads (%0d out of order), want %0d in order", read_log.size(), out_of_order(), nreads);
  endtask

  task automatic test_ignore_tail();
    bit ok;
    fill_default();
    mem[0] = coord_pack(6'd13, 5'd1); mem[1] = coord_pack(6'd12, 5'd1); mem[2] = coord_pack(6'd11, 5'd1);
    read_log.delete();
    issue(coord_pack(6'd11, 5'd1), 3, 1'b1, 1'b0, 0, 4);
    wait_idle(ok);
    checks++; if (ok) passed++; else $display("FAIL ignore_timeout: got no done in 40 cycles, want done");
    checks++;
    if (read_log.size() == 2 && out_of_order() == 0) passed++;
    else $display("FAIL ignore_reads: got %0d reads (%0d out of order), want 2 in order", read_log.size(), out_of_order());
    read_log.delete();
    issue(coord_pack(6'd11, 5'd1), 3, 1'b0, 1'b1, 2, 5);
    wait_idle(ok);
    checks++; if (ok) passed++; else $display("FAIL tail_timeout: got no done in 40 cycles, want done");
    checks++;
    if (read_log.size() == 3 && out_of_order() == 0) passed++;
    else $display("FAIL tail_reads: got %0d reads (%0d out of order), want 3 in order", read_log.size(), out_of_order());
  endtask

  task automatic test_boundaries();
    bit ok;
    fill_default();
    mem[0] = coord_pack(6'd13, 5'd1); mem[7] = coord_pack(6'd9, 5'd9);
    read_log.delete();
    issue(coord_pack(6'd13, 5'd1), 0, 1'b0, 1'b0, 0, 1);
    wait_idle(ok);
    issue(coord_pack(6'd13, 5'd1), 1, 1'b1, 1'b0, 0, 1);
    wait_idle(ok);
    checks++; if (ok) passed++; else $display("FAIL empty_timeout: got no done in 40 cycles, want done");
    checks++; if (read_log.size() == 0) passed++; else $display("FAIL empty_reads: got %0d reads, want 0", read_log.size());
    read_log.delete();
    issue(coord_pack(6'd5, 5'd5), 20, 1'b0, 1'b0, 0, 10);
    wait_idle(ok);
    checks++;
    if (ok && read_log.size() == MAX_LEN && out_of_order() == 0 && read_log[MAX_LEN-1] == MAX_LEN - 1) passed++;
    else $display("FAIL clamp_reads: got %0d reads (%0d out of order), want %0d ending at %0d", read_log.size(), out_of_order(), MAX_LEN, MAX_LEN - 1);
    issue(coord_pack(6'd9, 5'd9), 20, 1'b0, 1'b1, 7, 10);
    wait_idle(ok);
    checks++; if (ok) passed++; else $display("FAIL clamp_hit_timeout: got no done in 40 cycles, want done");
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n = 0;
    int d0;
    exp_t e;
    fill_default();
    mem[0] = coord_pack(6'd13, 5'd1); mem[1] = coord_pack(6'd12, 5'd1); mem[2] = coord_pack(6'd11, 5'd1);
    d0 = done_cnt;
    issue(coord_pack(6'd5, 5'd5), 3, 1'b0, 1'b0, 0, 5);
    // Start pulse while busy, with inputs that would hit at the head if used.
    query = coord_pack(6'd13, 5'd1); length = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++; if (done === 1'b1) passed++; else $display("FAIL b2b_first_done: got done=%0b after %0d cycles, want 1", done, n);
    query = coord_pack(6'd12, 5'd1); length = 8'd3; ignore_tail = 1'b0; start = 1'b1;
    e.hit = 1'b1; e.idx = AW'(1); e.t_acc = cyc + 2;
`ifdef SNAKE_SCAN_EARLY_EXIT_EN
    e.lat = 4;
`else
    e.lat = 5;
`endif
    exp_q.push_back(e);
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_idle(ok);
    checks++; if (ok) passed++; else $display("FAIL b2b_timeout: got no done in 40 cycles, want done");
    checks++; if (done_cnt - d0 == 2) passed++; else $display("FAIL b2b_done_count: got %0d done pulses, want 2", done_cnt - d0);
  endtask

  task automatic test_reset_mid_scan();
    bit ok;
    int d0;
    fill_default();
    read_log.delete();
    issue(coord_pack(6'd5, 5'd5), 8, 1'b0, 1'b0, 0, 10);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (rd_bus.rd_en === 1'b0 && rd_bus.rd_addr === '0 && busy === 1'b0 && done === 1'b0 && hit === 1'b0 && hit_idx === '0) passed++;
    else $display("FAIL abort_outputs: got rd_en=%0b rd_addr=%0d busy=%0b done=%0b hit=%0b hit_idx=%0d, want all 0",
                  rd_bus.rd_en, rd_bus.rd_addr, busy, done, hit, hit_idx);
    exp_q.delete();
    d0 = done_cnt;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (done_cnt == d0 && busy === 1'b0) passed++;
    else $display("FAIL abort_no_done: got %0d done pulses busy=%0b, want 0 pulses busy=0", done_cnt - d0, busy);
    mem[0] = coord_pack(6'd13, 5'd1); mem[1] = coord_pack(6'd12, 5'd1);
    mem[2] = coord_pack(6'd12, 5'd1); mem[3] = coord_pack(6'd10, 5'd1);
`ifdef SNAKE_SCAN_EARLY_EXIT_EN
    issue(coord_pack(6'd12, 5'd1), 4, 1'b0, 1'b1, 1, 4);
`else
    issue(coord_pack(6'd12, 5'd1), 4, 1'b0, 1'b1, 1, 6);
`endif
    wait_idle(ok);
    checks++; if (ok) passed++; else $display("FAIL fresh_timeout: got no done in 40 cycles, want done");
  endtask

  initial begin
    fill_default();
    test_reset();
    test_miss();
    test_dup_hit();
    test_ignore_tail();
    test_boundaries();
    test_back_to_back();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running at %0t, want finish", $time);
    $fatal(1);
  end

endmodule
